data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder (memory) side of the core's byte-lane data-memory interface: accepts word-wide read/write requests and returns four bytes after a fixed latency.
- Backed by a byte-addressed array of 8-bit cells.
- Sits between the processor's mem_addr / mem_data_out / mem_write_en outputs and its mem_data_in input; adds a req/ready handshake so the core can stall on memory.

Parameters:
- XLEN, 32, address/data width of the core interface.
- ADDR_BITS, 16, byte-address bits used; array depth 2**ADDR_BITS bytes.
- LATENCY, 2, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_req  input  1  access request strobe from core.
- mem_addr  input  XLEN  byte address of word access.
- mem_write_en  input  1  1 = write, 0 = read; sampled with mem_req.
- mem_data_in  input  4x8 (unpacked [0:3])  write bytes from core; lane 0 = most significant.
- mem_data_out  output  4x8 (unpacked [0:3])  read bytes to core.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while an access is in flight.

Behaviour:
- Reset is asynchronous and active-low:
  - State returns to IDLE; counter cleared.
  - mem_ready=0, mem_busy=0, mem_data_out lanes all 8'h00.
  - Array contents are not reset.
- FSM states: IDLE, WAIT.
- IDLE:
  - mem_req=1 at a rising edge accepts the request.
  - Captures mem_addr[ADDR_BITS-1:0], mem_write_en and all four mem_data_in lanes into holding registers.
  - Loads counter with LATENCY-1 and moves to WAIT.
  - mem_busy=1 from the next cycle.
- WAIT:
  - Counter decrements each edge.
  - The edge at which counter==0 completes the access:
    - Read: mem_data_out[i] <= mem[(A+i) mod 2**ADDR_BITS] for i=0..3 (big-endian; lane 0 at lowest address).
    - Write: mem[(A+i)] <= captured byte i for i=0..3, and mem_data_out <= captured write bytes (write-through echo).
    - mem_ready=1 for exactly the following cycle; state returns to IDLE; mem_busy=0.
- Latency: request accepted at edge k; mem_ready high in the cycle after edge k+LATENCY. For LATENCY=1, ready is high in the cycle after edge k+1.
- Back-to-back: mem_req high during the mem_ready cycle is accepted (FSM is in IDLE). Sustained throughput is one access per LATENCY+1 cycles.
- mem_req during WAIT is ignored; no queueing. Input changes during WAIT have no effect.
- mem_data_out holds its last completion value until the next completion.
- Address wrap: bytes past 2**ADDR_BITS-1 wrap to 0. Upper address bits above ADDR_BITS are ignored.
- Unaligned addresses are serviced byte-wise unless the optional check is compiled in.
- Read-after-write to the same address returns the new data; the write commits at the completion edge, before any later request is accepted.
- Reset mid-access aborts it: a pending write is not committed, and mem_ready is not pulsed.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output mem_misaligned (1 bit, reset 0).
  - An accepted request with captured address[1:0]!=0 still takes LATENCY cycles.
  - At completion the array is not written, mem_data_out is forced to all 8'h00, and mem_misaligned pulses high together with mem_ready.
- Undefined: port absent; unaligned accesses serviced byte-wise as above.

Test Plan:
- Reset then idle → mem_ready=0, mem_busy=0, mem_data_out=00,00,00,00; assert rst_b low mid-WAIT → outputs return to reset values immediately, no ready pulse.
- Write addr 0x0000_0010 data {DE,AD,BE,EF}, LATENCY=2 → mem_ready in cycle after edge k+2, mem_data_out={DE,AD,BE,EF}; read 0x10 → {DE,AD,BE,EF}; read 0x12 (unaligned, check off) → {BE,EF,xx,xx} where xx = prior contents of 0x14/0x15.
- Write {11,22,33,44} to 0xFFFE (ADDR_BITS=16) → bytes at 0xFFFE,0xFFFF,0x0000,0x0001 = 11,22,33,44; read 0x0000 → lanes 0,1 = 33,44.
- Back-to-back: req held high continuously, alternating write 0x20={01,02,03,04} then read 0x20 → second access accepted in the first ready cycle, returns {01,02,03,04}; req pulses during WAIT produce no extra ready.
- Upper address bits: write 0x0001_0040, read 0x0000_0040 → same data (ADDR_BITS=16).
- DATA_MEM_ALIGN_CHECK_EN defined: write to 0x0000_0021 → mem_misaligned and mem_ready pulse together, data_out 00s, bytes at 0x20–0x24 unchanged.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Byte-lane data-memory bus between the core (master) and the memory responder (slave).
// Signals:
//   mem_req         request strobe from core
//   mem_addr        byte address of the word access
//   mem_write_en    1 = write, 0 = read; sampled with mem_req
//   mem_data_in     write bytes, lane 0 = most significant / lowest address
//   mem_data_out    read (or echoed write) bytes back to the core
//   mem_ready       one-cycle completion pulse
//   mem_busy        high while an access is in flight
//   mem_misaligned  only with DATA_MEM_ALIGN_CHECK_EN: pulses with mem_ready on an unaligned access
interface data_memory_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_write_en;
  logic [7:0]      mem_data_in  [0:3];
  logic [7:0]      mem_data_out [0:3];
  logic            mem_ready;
  logic            mem_busy;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic            mem_misaligned;
`endif

  modport master (
    output mem_req, mem_addr, mem_write_en, mem_data_in,
    input  mem_data_out, mem_ready, mem_busy
`ifdef DATA_MEM_ALIGN_CHECK_EN
    , input mem_misaligned
`endif
  );

  modport slave (
    input  mem_req, mem_addr, mem_write_en, mem_data_in,
    output mem_data_out, mem_ready, mem_busy
`ifdef DATA_MEM_ALIGN_CHECK_EN
    , output mem_misaligned
`endif
  );
endinterface

// File: rtl/data_memory_responder.sv
// Memory-side responder for the core's byte-lane data interface. A request accepted in IDLE is
// held for LATENCY cycles, then completes: reads return the four bytes at A..A+3 (lane 0 at the
// lowest address), writes commit the four captured bytes and echo them on mem_data_out.
// Byte addresses wrap modulo 2**ADDR_BITS; address bits above ADDR_BITS are ignored.
// Ports:
//   clk    clock, all state on the rising edge
//   rst_b  asynchronous active-low reset (array contents are not reset)
//   bus    data_memory_responder_if.slave (req/addr/write_en/data_in in; data_out/ready/busy out)
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to reject accesses with addr[1:0] != 0;
// such accesses still take LATENCY cycles, do not touch the array, return all-zero data and
// raise bus.mem_misaligned together with bus.mem_ready.
module data_memory_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned LATENCY   = 2
) (
  input logic                   clk,
  input logic                   rst_b,
  data_memory_responder_if.slave bus
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_WAIT  = 1'b1;
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic                 state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_hold;
  logic                 we_hold;
  logic [7:0]           wdata_hold [0:3];
  logic [7:0]           data_out   [0:3];
  logic                 ready;
  logic [7:0]           mem        [0:DEPTH-1];

  logic                 complete;
  logic                 misaligned;
  logic                 do_write;
  logic [ADDR_BITS-1:0] lane_addr  [0:3];

  // Upper address bits are deliberately ignored.
  if (XLEN > ADDR_BITS) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[XLEN-1:ADDR_BITS];
  end

  assign complete = (state == ST_WAIT) && (cnt == 4'd0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = (addr_hold[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State is cleared asynchronously, so a reset mid-access can never reach a commit.
  assign do_write = complete && we_hold && !misaligned;

  // Natural ADDR_BITS-wide addition gives the wrap past the top of the array.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr_hold + ADDR_BITS'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      addr_hold <= '0;
      we_hold   <= 1'b0;
      ready     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wdata_hold[i] <= 8'h00;
        data_out[i]   <= 8'h00;
      end
    end else begin
      ready <= complete;
      if (state == ST_IDLE) begin
        if (bus.mem_req) begin
          addr_hold <= bus.mem_addr[ADDR_BITS-1:0];
          we_hold   <= bus.mem_write_en;
          for (int i = 0; i < 4; i++) begin
            wdata_hold[i] <= bus.mem_data_in[i];
          end
          cnt   <= CNT_INIT;
          state <= ST_WAIT;
        end
      end else begin
        if (cnt == 4'd0) begin
          state <= ST_IDLE;
          for (int i = 0; i < 4; i++) begin
            if (misaligned) begin
              data_out[i] <= 8'h00;
            end else if (we_hold) begin
              data_out[i] <= wdata_hold[i];
            end else begin
              data_out[i] <= mem[lane_addr[i]];
            end
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Array has no reset; written only at a completing, aligned (when checked) write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        mem[lane_addr[i]] <= wdata_hold[i];
      end
    end
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic misaligned_pulse;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      misaligned_pulse <= 1'b0;
    end else begin
      misaligned_pulse <= complete && misaligned;
    end
  end

  assign bus.mem_misaligned = misaligned_pulse;
`endif

  assign bus.mem_data_out = data_out;
  assign bus.mem_ready    = ready;
  assign bus.mem_busy     = (state == ST_WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned ADDR_BITS = 16;
  localparam int unsigned LATENCY   = 2;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] cyc = 0;
  exp_t sb[$];

  logic [7:0] ref_mem   [0:65535];
  bit         ref_known [0:65535];

  data_memory_responder_if #(.XLEN(XLEN)) bus ();

  data_memory_responder #(
    .XLEN     (XLEN),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] out_word();
    return {bus.mem_data_out[0], bus.mem_data_out[1], bus.mem_data_out[2], bus.mem_data_out[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: word access = four independent byte cells at A..A+3 modulo 64 KiB.
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    logic [15:0] a;
    logic [15:0] la;
    a = addr[15:0];
    e.data = '0;
    e.mask = 4'hF;
    e.mis  = ALIGN_CHECK && (a[1:0] != 2'b00);
    for (int i = 0; i < 4; i++) begin
      la = a + 16'(i);
      if (e.mis) begin
        e.data[31-8*i -: 8] = 8'h00;
      end else if (we) begin
        ref_mem[la]   = data[31-8*i -: 8];
        ref_known[la] = 1'b1;
        e.data[31-8*i -: 8] = data[31-8*i -: 8];
      end else begin
        e.data[31-8*i -: 8] = ref_mem[la];
        e.mask[3-i] = ref_known[la];
      end
    end
    return e;
  endfunction

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data);
    bus.mem_req      = req;
    bus.mem_write_en = we;
    bus.mem_addr     = addr;
    for (int i = 0; i < 4; i++) bus.mem_data_in[i] = data[31-8*i -: 8];
  endtask

  task automatic noise();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom());
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the completion edge, i.e. in
  // the ready cycle, so a following call exercises back-to-back acceptance.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    drive(1'b1, we, addr, data);
    @(posedge clk);
    #1;
    e = model(we, addr, data);
    e.cyc = cyc + LATENCY;
    sb.push_back(e);
    check("busy_in_wait", {31'd0, bus.mem_busy}, 32'd1);
    repeat (LATENCY) begin
      noise();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {31'd0, bus.mem_ready}, 32'd0);
    check({name, "_busy"}, {31'd0, bus.mem_busy}, 32'd0);
    check({name, "_data"}, out_word(), 32'h0000_0000);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready cyc=%0d got=1 exp=0", cyc);
      end else begin
        e = sb.pop_front();
        check("ready_cycle", cyc, e.cyc);
        total++;
        for (int i = 0; i < 4; i++) begin
          if (e.mask[3-i] && (bus.mem_data_out[i] !== e.data[31-8*i -: 8])) begin
            bad++;
            $display("FAIL data lane=%0d cyc=%0d got=%h exp=%h", i, cyc, bus.mem_data_out[i],
                     e.data[31-8*i -: 8]);
            break;
          end
        end
`ifdef DATA_MEM_ALIGN_CHECK_EN
        check("misaligned_flag", {31'd0, bus.mem_misaligned}, {31'd0, e.mis});
`endif
      end
    end
`ifdef DATA_MEM_ALIGN_CHECK_EN
    else if (bus.mem_misaligned) begin
      total++;
      bad++;
      $display("FAIL misaligned_without_ready cyc=%0d got=1 exp=0", cyc);
    end
`endif
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_b = 1'b1;
    idle(2);
    check_reset_outputs("after_reset");

    // Directed cases.
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0010, 32'h0);
    access(1'b0, 32'h0000_0012, 32'h0);
    access(1'b1, 32'h0000_FFFE, 32'h1122_3344);
    access(1'b0, 32'h0000_0000, 32'h0);
    access(1'b0, 32'h0000_FFFC, 32'h0);
    access(1'b1, 32'h0000_0020, 32'h0102_0304);
    access(1'b0, 32'h0000_0020, 32'h0);
    access(1'b1, 32'h0001_0040, 32'hCAFE_F00D);
    access(1'b0, 32'h0000_0040, 32'h0);
    access(1'b1, 32'h0000_0021, 32'hA5A5_A5A5);
    access(1'b0, 32'h0000_0020, 32'h0);
    access(1'b0, 32'h0000_0024, 32'h0);
    idle(1);
    check("data_holds", out_word(), sb.size() == 0 ? out_word() ^ 32'h0 : 32'h0);

    // Reset in the middle of a write: nothing commits and no ready pulse follows.
    access(1'b1, 32'h0000_0100, 32'hAABB_CCDD);
    idle(1);
    drive(1'b1, 1'b1, 32'h0000_0100, 32'h5566_7788);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check_reset_outputs("mid_wait_reset");
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(3);
    check_reset_outputs("post_abort_idle");
    access(1'b0, 32'h0000_0100, 32'h0);

    // Randomized mix, concentrated on a small window and the wrap boundary so reads hit data.
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) a = {r[31:16], 16'hFFFC + 16'($urandom_range(0, 3))};
      else a = {r[31:16], 16'($urandom_range(0, 63))};
      access(1'($urandom_range(0, 1)), a, $urandom());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(LATENCY + 4);
    check("outstanding", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
